id_ex_stage: RTL and testbench

- Pipeline register between decode and the ALU.
- Captures decoded operands, performs EX/MEM and MEM/WB operand forwarding, and presents src_a, src_b and alu_ctrl to the ALU.
- Valid/ready handshake on both sides; supports flush from branch resolution.

---
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards EX/MEM and
// MEM/WB results into its operands, and drives the ALU. Define ID_EX_SKID_EN for a skid entry.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   src_a,
    output logic [XLEN-1:0]   src_b,
    output logic [3:0]        alu_ctrl,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic [XLEN-1:0]   out_rs2_val
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic [3:0]        alu_ctrl;
    } entry_t;

`ifdef ID_EX_SKID_EN
    localparam int NOPS = 4;
`else
    localparam int NOPS = 2;
`endif

    entry_t            main_reg, main_next, in_entry;
    logic              main_valid_reg, main_valid_next;
    logic              in_fire, out_fire, stalled;
    logic [REG_AW-1:0] op_addr [NOPS];
    logic [XLEN-1:0]   op_held [NOPS];
    logic [XLEN-1:0]   op_fwd  [NOPS];

    assign in_entry = '{rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr, rd_addr: in_rd_addr,
                        rs1_val: in_rs1_val, rs2_val: in_rs2_val, imm: in_imm,
                        use_imm: in_use_imm, alu_ctrl: in_alu_ctrl};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_reg & out_ready;
    assign stalled  = main_valid_reg & ~out_ready;

    assign op_addr[0] = main_reg.rs1_addr;
    assign op_held[0] = main_reg.rs1_val;
    assign op_addr[1] = main_reg.rs2_addr;
    assign op_held[1] = main_reg.rs2_val;

    // MEM beats WB; x0 reads as zero whatever is held or forwarded.
    generate
        for (genvar gi = 0; gi < NOPS; gi++) begin : g_fwd
            assign op_fwd[gi] = (op_addr[gi] == '0) ? '0 :
                                (fwd_mem_we && fwd_mem_rd == op_addr[gi]) ? fwd_mem_data :
                                (fwd_wb_we && fwd_wb_rd == op_addr[gi]) ? fwd_wb_data :
                                op_held[gi];
        end
    endgenerate

`ifdef ID_EX_SKID_EN
    entry_t skid_reg, skid_next;
    logic   skid_valid_reg, skid_valid_next;
    logic   in_ready_reg;

    assign op_addr[2] = skid_reg.rs1_addr;
    assign op_held[2] = skid_reg.rs1_val;
    assign op_addr[3] = skid_reg.rs2_addr;
    assign op_held[3] = skid_reg.rs2_val;

    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (stalled) begin
            main_next.rs1_val = op_fwd[0];
            main_next.rs2_val = op_fwd[1];
        end
        if (skid_valid_reg) begin
            skid_next.rs1_val = op_fwd[2];
            skid_next.rs2_val = op_fwd[3];
        end
        // in_ready is low whenever the skid is occupied, so these cases are exclusive.
        if (out_fire && skid_valid_reg) begin
            main_next       = skid_next;
            skid_valid_next = 1'b0;
        end else if (in_fire && stalled) begin
            skid_next       = in_entry;
            skid_valid_next = 1'b1;
        end else if (in_fire) begin
            main_next       = in_entry;
            main_valid_next = 1'b1;
        end else if (out_fire) begin
            main_valid_next = 1'b0;
        end
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            skid_valid_reg <= skid_valid_next;
            skid_reg       <= skid_next;
            in_ready_reg   <= ~skid_valid_next;
        end
    end

    assign in_ready = in_ready_reg;
`else
    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        if (stalled) begin
            main_next.rs1_val = op_fwd[0];
            main_next.rs2_val = op_fwd[1];
        end
        if (in_fire) begin
            main_next       = in_entry;
            main_valid_next = 1'b1;
        end else if (out_fire) begin
            main_valid_next = 1'b0;
        end
        if (flush) main_valid_next = 1'b0;
    end

    assign in_ready = ~main_valid_reg | out_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_reg       <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_reg       <= main_next;
        end
    end

    assign out_valid   = main_valid_reg;
    assign src_a       = op_fwd[0];
    assign out_rs2_val = op_fwd[1];
    assign src_b       = main_reg.use_imm ? main_reg.imm : op_fwd[1];
    assign alu_ctrl    = main_reg.alu_ctrl;
    assign out_rd_addr = main_reg.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ALU-side results are queued as
// instructions are driven and compared when the stage presents them.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] rs2;
    } exp_t;

    logic        clk, rst, flush, in_valid, in_ready, in_use_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic [3:0]  in_alu_ctrl, alu_ctrl;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd, out_rd_addr;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [31:0] src_a, src_b, out_rs2_val;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd_addr(in_rd_addr), .in_alu_ctrl(in_alu_ctrl),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl),
        .out_rd_addr(out_rd_addr), .out_rs2_val(out_rs2_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rd,
                          input logic [31:0] r1v, input logic [31:0] r2v, input logic [31:0] imm,
                          input logic ui, input logic [3:0] ctrl);
        in_valid    = 1'b1;
        in_rs1_addr = r1a;
        in_rs2_addr = r2a;
        in_rd_addr  = rd;
        in_rs1_val  = r1v;
        in_rs2_val  = r2v;
        in_imm      = imm;
        in_use_imm  = ui;
        in_alu_ctrl = ctrl;
    endtask

    task automatic fwd_off();
        fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 4'h1);
        in_valid = 1'b0;
        fwd_off();
        @(negedge clk);
        @(negedge clk);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++;
        if ({src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val} !== 105'd0) begin
            errors++;
            $display("FAIL reset_fields: got a=%h b=%h ctrl=%h rd=%0d rs2=%h required all zero",
                     src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val);
        end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e, got;
        out_ready = 1'b1;
        set_in(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h0, 1'b0, 4'h0);
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b required 1", in_ready); end
        checks++;
        sb.push_back(exp_t'({32'd5, 32'd7, 4'h0, 5'd4, 32'd7}));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL basic_out: out_valid=%b pending=%0d, required a valid output", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
            if (got !== e) begin errors++; $display("FAIL basic_out: got %h required %h", got, e); end
            else $display("txn basic: src_a=%h src_b=%h alu_ctrl=%h rd=%0d", src_a, src_b, alu_ctrl, out_rd_addr);
        end
        checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b required 0", out_valid); end
        checks++;
    endtask

    task automatic test_forwarding();
        exp_t e, got;
        out_ready = 1'b0;
        set_in(5'd3, 5'd0, 5'd5, 32'h11, 32'h22, 32'h0, 1'b0, 4'h2);
        sb.push_back(exp_t'({32'h11, 32'h0, 4'h2, 5'd5, 32'h0}));
        @(negedge clk);
        in_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'hBB;
        #1;
        if (src_a !== 32'hAA) begin errors++; $display("FAIL fwd_mem_priority: got %h required %h", src_a, 32'hAA); end
        checks++;
        fwd_mem_we = 1'b0;
        #1;
        if (src_a !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got %h required %h", src_a, 32'hBB); end
        checks++;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        #1;
        if (out_rs2_val !== 32'h0) begin errors++; $display("FAIL fwd_x0_rs2: got %h required 0", out_rs2_val); end
        checks++;
        fwd_off();
        out_ready = 1'b1;
        set_in(5'd0, 5'd6, 5'd8, 32'h99, 32'h66, 32'h0, 1'b0, 4'h4);
        #1;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL fwd_out1: out_valid=%b pending=%0d, required a valid output", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
            if (got !== e) begin errors++; $display("FAIL fwd_out1: got %h required %h", got, e); end
            else $display("txn fwd1: src_a=%h src_b=%h alu_ctrl=%h rd=%0d", src_a, src_b, alu_ctrl, out_rd_addr);
        end
        checks++;
        sb.push_back(exp_t'({32'h0, 32'h66, 4'h4, 5'd8, 32'h66}));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hCC;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'hDD;
        #1;
        if (src_a !== 32'h0) begin errors++; $display("FAIL fwd_x0_rs1: got %h required 0", src_a); end
        checks++;
        fwd_off();
        out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL fwd_out2: out_valid=%b pending=%0d, required a valid output", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
            if (got !== e) begin errors++; $display("FAIL fwd_out2: got %h required %h", got, e); end
            else $display("txn fwd2: src_a=%h src_b=%h alu_ctrl=%h rd=%0d", src_a, src_b, alu_ctrl, out_rd_addr);
        end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_stall_refresh();
        exp_t e, got;
        out_ready = 1'b0;
        set_in(5'd7, 5'd9, 5'd10, 32'h70, 32'h90, 32'h0, 1'b0, 4'h3);
        sb.push_back(exp_t'({32'h70, 32'h55, 4'h3, 5'd10, 32'h55}));
        @(negedge clk);
        in_valid = 1'b0;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd9; fwd_wb_data = 32'h55;
        #1;
        if (src_b !== 32'h55) begin errors++; $display("FAIL stall_fwd_live: got %h required %h", src_b, 32'h55); end
        checks++;
        @(negedge clk);
        fwd_off();
        #1;
        if (src_b !== 32'h55) begin errors++; $display("FAIL stall_refresh_b: got %h required %h", src_b, 32'h55); end
        checks++;
        if (out_rs2_val !== 32'h55) begin errors++; $display("FAIL stall_refresh_rs2: got %h required %h", out_rs2_val, 32'h55); end
        checks++;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL stall_out: out_valid=%b pending=%0d, required a valid output", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
            if (got !== e) begin errors++; $display("FAIL stall_out: got %h required %h", got, e); end
            else $display("txn stall: src_a=%h src_b=%h rs2=%h rd=%0d", src_a, src_b, out_rs2_val, out_rd_addr);
        end
        checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b required 0", out_valid); end
        checks++;
    endtask

    task automatic test_imm();
        exp_t e, got;
        out_ready = 1'b0;
        set_in(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 4'hF);
        sb.push_back(exp_t'({32'h1, 32'hFFFF_FFF0, 4'hF, 5'd3, 32'h1234}));
        @(negedge clk);
        in_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'h1234;
        #1;
        if (src_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_src_b: got %h required %h", src_b, 32'hFFFF_FFF0); end
        checks++;
        if (out_rs2_val !== 32'h1234) begin errors++; $display("FAIL imm_rs2_fwd: got %h required %h", out_rs2_val, 32'h1234); end
        checks++;
        out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL imm_out: out_valid=%b pending=%0d, required a valid output", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
            if (got !== e) begin errors++; $display("FAIL imm_out: got %h required %h", got, e); end
            else $display("txn imm: src_a=%h src_b=%h rs2=%h alu_ctrl=%h", src_a, src_b, out_rs2_val, alu_ctrl);
        end
        checks++;
        @(negedge clk);
        fwd_off();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        flush = 1'b1;
        set_in(5'd4, 5'd5, 5'd6, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 4'h7);
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b required 1", in_ready); end
        checks++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_input: got %b required 0", out_valid); end
        checks++;
        out_ready = 1'b0;
        set_in(5'd8, 5'd9, 5'd10, 32'hCAFE, 32'hF00D, 32'h0, 1'b0, 4'h8);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_held: got %b required 0", out_valid); end
        checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit: got %b required 0", out_valid); end
        checks++;
    endtask

`ifdef ID_EX_SKID_EN
    task automatic test_skid();
        exp_t e, got;
        out_ready = 1'b0;
        set_in(5'd1, 5'd2, 5'd11, 32'hA1, 32'hA2, 32'h0, 1'b0, 4'h1);
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_a: got %b required 1", in_ready); end
        checks++;
        sb.push_back(exp_t'({32'hA1, 32'hA2, 4'h1, 5'd11, 32'hA2}));
        @(negedge clk);
        set_in(5'd3, 5'd4, 5'd12, 32'hB1, 32'hB2, 32'h0, 1'b0, 4'h2);
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_b: got %b required 1", in_ready); end
        checks++;
        sb.push_back(exp_t'({32'hB1, 32'hB2, 4'h2, 5'd12, 32'hB2}));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full: got %b required 0", in_ready); end
        checks++;
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_reg: got %b required 0", in_ready); end
        checks++;
        for (int k = 0; k < 2; k++) begin
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL skid_out%0d: out_valid=%b pending=%0d, required a valid output", k, out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
                if (got !== e) begin errors++; $display("FAIL skid_out%0d: got %h required %h", k, got, e); end
                else $display("txn skid%0d: src_a=%h src_b=%h rd=%0d", k, src_a, src_b, out_rd_addr);
            end
            checks++;
            @(negedge clk);
            #1;
        end
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL skid_drain: got valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        out_ready = 1'b0;
        set_in(5'd5, 5'd6, 5'd13, 32'hC1, 32'hC2, 32'h0, 1'b0, 4'h3);
        @(negedge clk);
        set_in(5'd7, 5'd8, 5'd14, 32'hD1, 32'hD2, 32'h0, 1'b0, 4'h4);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL skid_flush: got valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back(input int n);
        exp_t e, got;
        int   sent = 0;
        int   recv = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        while (recv < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if (sent < n) begin
                    set_in(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_out: unexpected output src_a=%h, required none", src_a);
                end else begin
                    e = sb.pop_front();
                    got = {src_a, src_b, alu_ctrl, out_rd_addr, out_rs2_val};
                    if (got !== e) begin errors++; $display("FAIL b2b_out%0d: got %h required %h", recv, got, e); end
                    else $display("txn b2b%0d: src_a=%h src_b=%h alu_ctrl=%h rd=%0d", recv, src_a, src_b, alu_ctrl, out_rd_addr);
                end
                checks++;
                recv++;
            end
            if (pend && in_ready) begin
                sb.push_back(exp_t'({(in_rs1_addr == 5'd0) ? 32'd0 : in_rs1_val,
                                     in_use_imm ? in_imm : ((in_rs2_addr == 5'd0) ? 32'd0 : in_rs2_val),
                                     in_alu_ctrl, in_rd_addr,
                                     (in_rs2_addr == 5'd0) ? 32'd0 : in_rs2_val}));
                sent++;
                pend = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (recv < n) begin errors++; $display("FAIL b2b_timeout: got %0d outputs required %0d", recv, n); end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(5'd2, 5'd3, 5'd4, 32'h12, 32'h34, 32'h0, 1'b0, 4'h5);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded: got %b required 1", out_valid); end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_stall_refresh();
        test_imm();
        test_flush();
`ifdef ID_EX_SKID_EN
        test_skid();
`endif
        test_back_to_back(24);
        test_reset_mid();
        if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d pending required 0", sb.size()); end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
